// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: a circular FIFO decouples the core from the line
// rate, and a registered serialiser emits start/data/parity/stop frames.
`timescale 1ns/1ps
module uart_tx_fifo #(
  parameter int CLK_FRE   = 27,
  parameter int BAUD_RATE = 115200,
  parameter int DEPTH     = 16,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                     in_clk,
  input  logic                     rst,
  input  logic [DATA_BITS-1:0]     wr_data,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  input  logic                     flush,
  output logic                     tx_pin,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow
);

  localparam int CPB   = (CLK_FRE * 1_000_000) / BAUD_RATE;
  localparam int CPB_W = $clog2(CPB);
  localparam int AW    = $clog2(DEPTH);
  localparam int BIT_W = $clog2(DATA_BITS);
  localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);

  if (CPB < 4) begin : g_bad_cpb
    $error("uart_tx_fifo: clocks per bit (%0d) must be at least 4", CPB);
  end
  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("uart_tx_fifo: DEPTH (%0d) must be a power of 2 and >= 2", DEPTH);
  end

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [CPB_W-1:0]       r_baud;
  logic [BIT_W-1:0]       r_bit;
  logic [DATA_BITS-1:0]   r_shift;
  logic                   r_par;
  logic                   r_tx;
  logic                   w_tx_nxt;

  logic [DATA_BITS-1:0]   r_mem [DEPTH];
  logic [AW-1:0]          r_rd_ptr;
  logic [AW-1:0]          r_wr_ptr;
  logic [AW:0]            r_level;
  logic                   r_overflow;

  logic                   w_full;
  logic                   w_push;
  logic                   w_pop;
  logic                   w_baud_end;

  function automatic logic parity_bit(input logic [DATA_BITS-1:0] d);
    parity_bit = (PARITY == 1) ? ~(^d) : (^d);
  endfunction

  // Flush wins over both the write and the IDLE pop on the same edge.
  assign w_full     = (r_level == LVL_FULL);
  assign w_push     = wr_valid && !w_full && !flush;
  assign w_pop      = (r_state == S_IDLE) && (r_level != '0) && !flush;
  assign w_baud_end = (r_baud == CPB_W'(CPB - 1));

  always_ff @(posedge in_clk or negedge rst) begin
    if (!rst) begin
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_level    <= '0;
      r_overflow <= 1'b0;
    end else if (flush) begin
      r_rd_ptr   <= r_wr_ptr;
      r_level    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      if (w_push && !w_pop)      r_level <= r_level + (AW+1)'(1);
      else if (!w_push && w_pop) r_level <= r_level - (AW+1)'(1);
      if (wr_valid && w_full) r_overflow <= 1'b1;
    end
  end

  always_ff @(posedge in_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= wr_data;
  end

  always_ff @(posedge in_clk) begin
    if (w_pop) begin
      r_shift <= r_mem[r_rd_ptr];
      r_par   <= parity_bit(r_mem[r_rd_ptr]);
    end else if ((r_state == S_DATA) && w_baud_end) begin
      r_shift <= r_shift >> 1;
    end
  end

  // Bit counter indexes data bits in DATA and stop bits in STOP.
  always_ff @(posedge in_clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_tx    <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_tx    <= w_tx_nxt;
      if (w_state_nxt != r_state) begin
        r_baud <= '0;
        r_bit  <= '0;
      end else if (w_baud_end) begin
        r_baud <= '0;
        r_bit  <= r_bit + BIT_W'(1);
      end else begin
        r_baud <= r_baud + CPB_W'(1);
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_tx_nxt    = 1'b1;
    case (r_state)
      S_IDLE: begin
        if (w_pop) w_state_nxt = S_START;
      end
      S_START: begin
        w_tx_nxt = 1'b0;
        if (w_baud_end) w_state_nxt = S_DATA;
      end
      S_DATA: begin
        w_tx_nxt = r_shift[0];
        if (w_baud_end && (r_bit == BIT_W'(DATA_BITS - 1)))
          w_state_nxt = (PARITY != 0) ? S_PAR : S_STOP;
      end
      S_PAR: begin
        w_tx_nxt = r_par;
        if (w_baud_end) w_state_nxt = S_STOP;
      end
      S_STOP: begin
        if (w_baud_end && (r_bit == BIT_W'(STOP_BITS - 1))) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign wr_ready = !w_full;
  assign tx_pin   = r_tx;
  assign busy     = (r_state != S_IDLE) || (r_level != '0);
  assign level    = r_level;
  assign overflow = r_overflow;

endmodule
